// File: rtl/debounce_pkg.sv
// Shared defaults for the multi-channel key debouncer, including the
// 50 MHz / 20 ms hold-time derivation and the per-cycle counter action type.
package debounce_pkg;

  localparam int unsigned CLK_HZ      = 50_000_000;
  localparam int unsigned DEBOUNCE_MS = 20;

  localparam int unsigned DEF_NUM_CH          = 4;
  localparam int unsigned DEF_CNT_W           = 20;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = (CLK_HZ / 1000) * DEBOUNCE_MS;

  typedef enum logic [1:0] {
    ACT_CLEAR  = 2'd0,
    ACT_COUNT  = 2'd1,
    ACT_ACCEPT = 2'd2
  } cnt_act_e;

endpackage

// File: rtl/debounce_ch.sv
// Single debounce channel: 2-flop synchroniser, hold counter and, when
// KEY_DEBOUNCE_EDGE_EN is defined, registered rise/fall pulses.
module debounce_ch
  import debounce_pkg::*;
#(
  parameter int unsigned CNT_W           = DEF_CNT_W,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter logic        INIT_LEVEL      = 1'b1
) (
  input  logic clk,
  input  logic rstn,
  input  logic in,
  input  logic en,
  output logic out,
  output logic rise,
  output logic fall
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync;
  logic [CNT_W-1:0] cnt;
  cnt_act_e         act;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) sync <= {2{INIT_LEVEL}};
    else       sync <= {sync[0], in};
  end

  // Any cycle without an enabled mismatch discards accumulated credit.
  always_comb begin
    act = ACT_CLEAR;
    if (en && (sync[1] != out)) act = (cnt == LAST) ? ACT_ACCEPT : ACT_COUNT;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
      out <= INIT_LEVEL;
    end else begin
      case (act)
        ACT_COUNT: cnt <= cnt + CNT_W'(1);
        default:   cnt <= '0;
      endcase
      if (act == ACT_ACCEPT) out <= sync[1];
    end
  end

`ifdef KEY_DEBOUNCE_EDGE_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= (act == ACT_ACCEPT) &&  sync[1];
      fall <= (act == ACT_ACCEPT) && !sync[1];
    end
  end
`else
  assign rise = 1'b0;
  assign fall = 1'b0;
`endif

endmodule

// File: rtl/key_debounce_multi.sv
// NUM_CH independent key debouncers; rise/fall pulses exist only when
// KEY_DEBOUNCE_EDGE_EN is defined, otherwise they are tied to 0.
module key_debounce_multi
  import debounce_pkg::*;
#(
  parameter int unsigned NUM_CH          = DEF_NUM_CH,
  parameter int unsigned CNT_W           = DEF_CNT_W,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter logic        INIT_LEVEL      = 1'b1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [NUM_CH-1:0] in,
  input  logic [NUM_CH-1:0] en,
  output logic [NUM_CH-1:0] out,
  output logic [NUM_CH-1:0] rise,
  output logic [NUM_CH-1:0] fall
);

  if (NUM_CH < 1 || NUM_CH > 32) begin : g_bad_num_ch
    $error("key_debounce_multi: NUM_CH must be 1..32");
  end

  if (CNT_W < 1 || CNT_W > 32 || DEBOUNCE_CYCLES == 0 ||
      64'(DEBOUNCE_CYCLES) >= (64'd1 << CNT_W)) begin : g_bad_cycles
    $error("key_debounce_multi: DEBOUNCE_CYCLES must be 1..2^CNT_W-1");
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    debounce_ch #(
      .CNT_W          (CNT_W),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .INIT_LEVEL     (INIT_LEVEL)
    ) u_ch (
      .clk (clk),
      .rstn(rstn),
      .in  (in[g]),
      .en  (en[g]),
      .out (out[g]),
      .rise(rise[g]),
      .fall(fall[g])
    );
  end

endmodule
